// File: rtl/miriscv_decode_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : miriscv_decode_pkg
//  Description : Types, encodings and immediate helper for the decode stage.
//  Revision    : 1.0 - initial release
// ============================================================================
package miriscv_decode_pkg;

    // Fence serialisation FSM
    typedef enum logic [1:0] {
        RUN        = 2'd0,
        FENCE_HOLD = 2'd1,
        FENCE_WAIT = 2'd2
    } fsm_state_e;

    // Write-back source select
    localparam logic [2:0] ALU_DATA = 3'd0;
    localparam logic [2:0] MDU_DATA = 3'd1;
    localparam logic [2:0] LSU_DATA = 3'd2;
    localparam logic [2:0] PC_DATA  = 3'd3;
    localparam logic [2:0] IMM_DATA = 3'd4;

    typedef enum logic [2:0] {
        IMM_NONE = 3'd0,
        IMM_I    = 3'd1,
        IMM_S    = 3'd2,
        IMM_B    = 3'd3,
        IMM_U    = 3'd4,
        IMM_J    = 3'd5
    } imm_type_e;

    typedef struct packed {
        logic [4:0]  rs1;
        logic [4:0]  rs2;
        logic [4:0]  rd;
        logic [31:0] imm;
        logic        op1_sel;
        logic        op2_sel;
        logic [3:0]  alu_op;
        logic        mdu_req;
        logic [2:0]  mdu_op;
        logic        mem_req;
        logic        mem_we;
        logic [2:0]  mem_size;
        logic        wb_we;
        logic [2:0]  wb_src;
        logic        branch;
        logic        jal;
        logic        jalr;
        logic        fence;
        logic        illegal;
    } decoded_t;

    // Sign-extended immediate for the given instruction format
    function automatic logic [31:0] gen_imm(input logic [31:0] ins, input imm_type_e t);
        logic [31:0] v;
        case (t)
            IMM_I:   v = {{21{ins[31]}}, ins[30:20]};
            IMM_S:   v = {{21{ins[31]}}, ins[30:25], ins[11:7]};
            IMM_B:   v = {{20{ins[31]}}, ins[7], ins[30:25], ins[11:8], 1'b0};
            IMM_U:   v = {ins[31:12], 12'h000};
            IMM_J:   v = {{12{ins[31]}}, ins[19:12], ins[20], ins[30:21], 1'b0};
            default: v = 32'h0;
        endcase
        return v;
    endfunction

endpackage
`default_nettype wire

// File: rtl/miriscv_opcodes_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : miriscv_opcodes_pkg
//  Description : RV32I major opcode constants for the miriscv core.
//  Revision    : 1.0 - initial release
// ============================================================================
package miriscv_opcodes_pkg;

    localparam logic [6:0] c_opc_lui    = 7'b0110111;
    localparam logic [6:0] c_opc_auipc  = 7'b0010111;
    localparam logic [6:0] c_opc_jal    = 7'b1101111;
    localparam logic [6:0] c_opc_jalr   = 7'b1100111;
    localparam logic [6:0] c_opc_branch = 7'b1100011;
    localparam logic [6:0] c_opc_load   = 7'b0000011;
    localparam logic [6:0] c_opc_store  = 7'b0100011;
    localparam logic [6:0] c_opc_opimm  = 7'b0010011;
    localparam logic [6:0] c_opc_op     = 7'b0110011;
    localparam logic [6:0] c_opc_fence  = 7'b0001111;
    localparam logic [6:0] c_opc_system = 7'b1110011;

endpackage
`default_nettype wire

// File: rtl/miriscv_decode_logic.sv
`default_nettype none
// ============================================================================
//  Module      : miriscv_decode_logic
//  Description : Combinational RV32I(M/E) instruction decoder with legality.
//  Revision    : 1.0 - initial release
// ============================================================================
module miriscv_decode_logic
    import miriscv_opcodes_pkg::*;
    import miriscv_decode_pkg::*;
#(
    parameter int unsigned RV32M = 1,
    parameter int unsigned RV32E = 0
) (
    input  logic [31:0] i_instr,
    output decoded_t    o_dec
);

    logic [6:0] w_opc;
    logic [2:0] w_f3;
    logic [6:0] w_f7;
    imm_type_e  w_imm_type;
    logic       w_known, w_bad, w_use_rs1, w_use_rs2, w_use_rd, w_e_bad;
    decoded_t   w_dec;

    assign w_opc = i_instr[6:0];
    assign w_f3  = i_instr[14:12];
    assign w_f7  = i_instr[31:25];

    // Field decode, format legality and forced suppression of side effects
    always_comb begin
        w_dec          = '0;
        w_dec.rs1      = i_instr[19:15];
        w_dec.rs2      = i_instr[24:20];
        w_dec.rd       = i_instr[11:7];
        w_imm_type     = IMM_NONE;
        w_known        = 1'b1;
        w_bad          = 1'b0;
        w_use_rs1      = 1'b0;
        w_use_rs2      = 1'b0;
        w_use_rd       = 1'b0;
        case (w_opc)
            c_opc_lui: begin
                w_imm_type = IMM_U; w_use_rd = 1'b1;
                w_dec.op2_sel = 1'b1; w_dec.wb_we = 1'b1; w_dec.wb_src = IMM_DATA;
            end
            c_opc_auipc: begin
                w_imm_type = IMM_U; w_use_rd = 1'b1;
                w_dec.op1_sel = 1'b1; w_dec.op2_sel = 1'b1;
                w_dec.wb_we = 1'b1; w_dec.wb_src = ALU_DATA;
            end
            c_opc_jal: begin
                w_imm_type = IMM_J; w_use_rd = 1'b1; w_dec.jal = 1'b1;
                w_dec.op1_sel = 1'b1; w_dec.op2_sel = 1'b1;
                w_dec.wb_we = 1'b1; w_dec.wb_src = PC_DATA;
            end
            c_opc_jalr: begin
                w_imm_type = IMM_I; w_use_rs1 = 1'b1; w_use_rd = 1'b1; w_dec.jalr = 1'b1;
                w_dec.op2_sel = 1'b1; w_dec.wb_we = 1'b1; w_dec.wb_src = PC_DATA;
                w_bad = (w_f3 != 3'd0);
            end
            c_opc_branch: begin
                w_imm_type = IMM_B; w_use_rs1 = 1'b1; w_use_rs2 = 1'b1; w_dec.branch = 1'b1;
                w_dec.alu_op = {1'b0, w_f3};
                w_bad = (w_f3 == 3'd2) || (w_f3 == 3'd3);
            end
            c_opc_load: begin
                w_imm_type = IMM_I; w_use_rs1 = 1'b1; w_use_rd = 1'b1;
                w_dec.op2_sel = 1'b1; w_dec.mem_req = 1'b1; w_dec.mem_size = w_f3;
                w_dec.wb_we = 1'b1; w_dec.wb_src = LSU_DATA;
                w_bad = (w_f3 == 3'd3) || (w_f3[2:1] == 2'b11);
            end
            c_opc_store: begin
                w_imm_type = IMM_S; w_use_rs1 = 1'b1; w_use_rs2 = 1'b1;
                w_dec.op2_sel = 1'b1; w_dec.mem_req = 1'b1; w_dec.mem_we = 1'b1;
                w_dec.mem_size = w_f3;
                w_bad = (w_f3 > 3'd2);
            end
            c_opc_opimm: begin
                w_imm_type = IMM_I; w_use_rs1 = 1'b1; w_use_rd = 1'b1;
                w_dec.op2_sel = 1'b1; w_dec.wb_we = 1'b1; w_dec.wb_src = ALU_DATA;
                // Only shift-right carries a funct7 qualifier (SRAI)
                w_dec.alu_op = {(w_f3 == 3'd5) && i_instr[30], w_f3};
                if (w_f3 == 3'd1)
                    w_bad = (w_f7 != 7'h00);
                else if (w_f3 == 3'd5)
                    w_bad = (w_f7 != 7'h00) && (w_f7 != 7'h20);
            end
            c_opc_op: begin
                w_use_rs1 = 1'b1; w_use_rs2 = 1'b1; w_use_rd = 1'b1;
                w_dec.wb_we  = 1'b1;
                w_dec.alu_op = {w_f7 == 7'h20, w_f3};
                if (w_f7 == 7'h01) begin
                    w_dec.mdu_req = 1'b1;
                    w_dec.mdu_op  = w_f3;
                    w_dec.wb_src  = MDU_DATA;
                    w_bad         = (RV32M == 0);
                end else if (w_f7 == 7'h20) begin
                    w_dec.wb_src = ALU_DATA;
                    w_bad        = (w_f3 != 3'd0) && (w_f3 != 3'd5);
                end else begin
                    w_dec.wb_src = ALU_DATA;
                    w_bad        = (w_f7 != 7'h00);
                end
            end
            c_opc_fence: begin
                w_dec.fence = 1'b1;
                w_bad       = (w_f3 != 3'd0);
            end
            c_opc_system: begin
                // CSR forms read rs1 and name rd, so both count for RV32E
                w_imm_type = IMM_I; w_use_rs1 = 1'b1; w_use_rd = 1'b1;
            end
            default: w_known = 1'b0;
        endcase

        w_e_bad = (RV32E != 0) && ((w_use_rs1 && i_instr[19]) ||
                                   (w_use_rs2 && i_instr[24]) ||
                                   (w_use_rd  && i_instr[11]));

        w_dec.imm     = gen_imm(i_instr, w_imm_type);
        w_dec.illegal = !w_known || w_bad || w_e_bad;
        // Illegal entries still flow but must not cause architectural effects
        if (w_dec.illegal) begin
            w_dec.wb_we   = 1'b0;
            w_dec.mem_req = 1'b0;
            w_dec.mdu_req = 1'b0;
        end
    end

    assign o_dec = w_dec;

endmodule
`default_nettype wire

// File: rtl/miriscv_decode_stage.sv
`default_nettype none
// ============================================================================
//  Module      : miriscv_decode_stage
//  Description : Registered decode stage with 2-entry skid buffer, FENCE
//                serialisation FSM and saturating illegal-instruction counter.
//  Revision    : 1.0 - initial release
// ============================================================================
module miriscv_decode_stage
    import miriscv_decode_pkg::*;
#(
    parameter int unsigned XLEN  = 32,
    parameter int unsigned RV32M = 1,
    parameter int unsigned RV32E = 0,
    parameter int unsigned CNT_W = 16
) (
    input  logic             clk_i,
    input  logic             arstn_i,
    input  logic             flush_i,
    input  logic             f_valid_i,
    output logic             f_ready_o,
    input  logic [31:0]      f_instr_i,
    input  logic [XLEN-1:0]  f_pc_i,
    output logic             d_valid_o,
    input  logic             d_ready_i,
    output logic [XLEN-1:0]  d_pc_o,
    output logic [4:0]       d_rs1_addr_o,
    output logic [4:0]       d_rs2_addr_o,
    output logic [4:0]       d_rd_addr_o,
    output logic [XLEN-1:0]  d_imm_o,
    output logic             d_op1_sel_o,
    output logic             d_op2_sel_o,
    output logic [3:0]       d_alu_op_o,
    output logic             d_mdu_req_o,
    output logic [2:0]       d_mdu_op_o,
    output logic             d_mem_req_o,
    output logic             d_mem_we_o,
    output logic [2:0]       d_mem_size_o,
    output logic             d_wb_we_o,
    output logic [2:0]       d_wb_src_sel_o,
    output logic             d_branch_o,
    output logic             d_jal_o,
    output logic             d_jalr_o,
    output logic             d_fence_o,
    output logic             d_illegal_o,
    input  logic             fence_done_i,
    output logic [CNT_W-1:0] illegal_cnt_o
);

    decoded_t         w_dec;
    decoded_t         r_out, r_skid;
    logic             r_out_vld, r_skid_vld;
    logic [XLEN-1:0]  r_out_pc, r_skid_pc;
    fsm_state_e       r_state;
    logic [CNT_W-1:0] r_cnt;
    logic             w_accept, w_handoff;

    miriscv_decode_logic #(
        .RV32M (RV32M),
        .RV32E (RV32E)
    ) u_decode (
        .i_instr (f_instr_i),
        .o_dec   (w_dec)
    );

    assign f_ready_o = !r_skid_vld && (r_state == RUN);
    assign w_accept  = f_valid_i && f_ready_o && !flush_i;
    assign w_handoff = r_out_vld && d_ready_i;

    // Output/skid registers: skid drains first so fetch order is preserved
    always_ff @(posedge clk_i) begin
        if (!arstn_i) begin
            r_out_vld  <= 1'b0;
            r_skid_vld <= 1'b0;
            r_out      <= '0;
            r_skid     <= '0;
            r_out_pc   <= '0;
            r_skid_pc  <= '0;
        end else if (flush_i) begin
            r_out_vld  <= 1'b0;
            r_skid_vld <= 1'b0;
        end else if (!r_out_vld || w_handoff) begin
            if (r_skid_vld) begin
                r_out      <= r_skid;
                r_out_pc   <= r_skid_pc;
                r_out_vld  <= 1'b1;
                r_skid_vld <= 1'b0;
            end else if (w_accept) begin
                r_out      <= w_dec;
                r_out_pc   <= f_pc_i;
                r_out_vld  <= 1'b1;
            end else begin
                r_out_vld  <= 1'b0;
            end
        end else if (w_accept) begin
            r_skid     <= w_dec;
            r_skid_pc  <= f_pc_i;
            r_skid_vld <= 1'b1;
        end
    end

    // FENCE serialisation: block fetch until the fence has left and memory drained
    always_ff @(posedge clk_i) begin
        if (!arstn_i || flush_i) begin
            r_state <= RUN;
        end else begin
            case (r_state)
                RUN:        if (w_accept && w_dec.fence && !w_dec.illegal) r_state <= FENCE_HOLD;
                FENCE_HOLD: if (w_handoff && r_out.fence && !r_out.illegal) r_state <= FENCE_WAIT;
                FENCE_WAIT: if (fence_done_i) r_state <= RUN;
                default:    r_state <= RUN;
            endcase
        end
    end

    // Saturating count of illegal entries handed to execute
    always_ff @(posedge clk_i) begin
        if (!arstn_i)
            r_cnt <= '0;
        else if (w_handoff && r_out.illegal && (r_cnt != {CNT_W{1'b1}}))
            r_cnt <= r_cnt + 1'b1;
    end

    generate
        if (XLEN > 32) begin : g_imm_wide
            assign d_imm_o = {{(XLEN-32){r_out.imm[31]}}, r_out.imm};
        end else begin : g_imm_narrow
            assign d_imm_o = r_out.imm[XLEN-1:0];
        end
    endgenerate

    assign d_valid_o      = r_out_vld;
    assign d_pc_o         = r_out_pc;
    assign d_rs1_addr_o   = r_out.rs1;
    assign d_rs2_addr_o   = r_out.rs2;
    assign d_rd_addr_o    = r_out.rd;
    assign d_op1_sel_o    = r_out.op1_sel;
    assign d_op2_sel_o    = r_out.op2_sel;
    assign d_alu_op_o     = r_out.alu_op;
    assign d_mdu_req_o    = r_out.mdu_req;
    assign d_mdu_op_o     = r_out.mdu_op;
    assign d_mem_req_o    = r_out.mem_req;
    assign d_mem_we_o     = r_out.mem_we;
    assign d_mem_size_o   = r_out.mem_size;
    assign d_wb_we_o      = r_out.wb_we;
    assign d_wb_src_sel_o = r_out.wb_src;
    assign d_branch_o     = r_out.branch;
    assign d_jal_o        = r_out.jal;
    assign d_jalr_o       = r_out.jalr;
    assign d_fence_o      = r_out.fence;
    assign d_illegal_o    = r_out.illegal;
    assign illegal_cnt_o  = r_cnt;

endmodule
`default_nettype wire

// File: tb/tb_miriscv_decode_stage.sv
`default_nettype none
// ============================================================================
//  Module      : tb_miriscv_decode_stage
//  Description : Self-checking bench for miriscv_decode_stage. Two instances:
//                A = RV32M=1/RV32E=0/CNT_W=16, B = RV32M=0/RV32E=1/CNT_W=3.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_miriscv_decode_stage;

    logic        clk = 1'b0;
    logic        rstn = 1'b0, flush = 1'b0, f_valid = 1'b0, d_ready = 1'b0, fence_done = 1'b0;
    logic [31:0] f_instr = '0, f_pc = '0;

    logic        f_ready_a, d_valid_a, op1_a, op2_a, mdu_req_a, mem_req_a, mem_we_a, wb_we_a;
    logic        br_a, jal_a, jalr_a, fence_a, ill_a;
    logic [31:0] d_pc_a, imm_a;
    logic [4:0]  rs1_a, rs2_a, rd_a;
    logic [3:0]  alu_a;
    logic [2:0]  mdu_op_a, mem_size_a, wb_src_a;
    logic [15:0] cnt_a;

    logic        f_ready_b, d_valid_b, op1_b, op2_b, mdu_req_b, mem_req_b, mem_we_b, wb_we_b;
    logic        br_b, jal_b, jalr_b, fence_b, ill_b;
    logic [31:0] d_pc_b, imm_b;
    logic [4:0]  rs1_b, rs2_b, rd_b;
    logic [3:0]  alu_b;
    logic [2:0]  mdu_op_b, mem_size_b, wb_src_b;
    logic [2:0]  cnt_b;

    int n_cmp = 0;
    int n_err = 0;

    localparam logic [31:0] ADDI  = 32'h00500093;
    localparam logic [31:0] MUL   = 32'h02208033;
    localparam logic [31:0] ADD16 = 32'h00000833;
    localparam logic [31:0] FENCE = 32'h0FF0000F;

    always #5 clk = ~clk;

    miriscv_decode_stage #(.XLEN(32), .RV32M(1), .RV32E(0), .CNT_W(16)) u_dut_a (
        .clk_i(clk), .arstn_i(rstn), .flush_i(flush), .f_valid_i(f_valid), .f_ready_o(f_ready_a),
        .f_instr_i(f_instr), .f_pc_i(f_pc), .d_valid_o(d_valid_a), .d_ready_i(d_ready),
        .d_pc_o(d_pc_a), .d_rs1_addr_o(rs1_a), .d_rs2_addr_o(rs2_a), .d_rd_addr_o(rd_a),
        .d_imm_o(imm_a), .d_op1_sel_o(op1_a), .d_op2_sel_o(op2_a), .d_alu_op_o(alu_a),
        .d_mdu_req_o(mdu_req_a), .d_mdu_op_o(mdu_op_a), .d_mem_req_o(mem_req_a),
        .d_mem_we_o(mem_we_a), .d_mem_size_o(mem_size_a), .d_wb_we_o(wb_we_a),
        .d_wb_src_sel_o(wb_src_a), .d_branch_o(br_a), .d_jal_o(jal_a), .d_jalr_o(jalr_a),
        .d_fence_o(fence_a), .d_illegal_o(ill_a), .fence_done_i(fence_done), .illegal_cnt_o(cnt_a)
    );

    miriscv_decode_stage #(.XLEN(32), .RV32M(0), .RV32E(1), .CNT_W(3)) u_dut_b (
        .clk_i(clk), .arstn_i(rstn), .flush_i(flush), .f_valid_i(f_valid), .f_ready_o(f_ready_b),
        .f_instr_i(f_instr), .f_pc_i(f_pc), .d_valid_o(d_valid_b), .d_ready_i(d_ready),
        .d_pc_o(d_pc_b), .d_rs1_addr_o(rs1_b), .d_rs2_addr_o(rs2_b), .d_rd_addr_o(rd_b),
        .d_imm_o(imm_b), .d_op1_sel_o(op1_b), .d_op2_sel_o(op2_b), .d_alu_op_o(alu_b),
        .d_mdu_req_o(mdu_req_b), .d_mdu_op_o(mdu_op_b), .d_mem_req_o(mem_req_b),
        .d_mem_we_o(mem_we_b), .d_mem_size_o(mem_size_b), .d_wb_we_o(wb_we_b),
        .d_wb_src_sel_o(wb_src_b), .d_branch_o(br_b), .d_jal_o(jal_b), .d_jalr_o(jalr_b),
        .d_fence_o(fence_b), .d_illegal_o(ill_b), .fence_done_i(fence_done), .illegal_cnt_o(cnt_b)
    );

    typedef struct packed {
        logic        ill, wb_we, mem_req, mem_we, mdu_req, br, jal, jalr, fence;
        logic [31:0] imm;
    } exp_t;

    // Reference decode straight from the ISA rules, immediates by arithmetic
    function automatic exp_t model(input logic [31:0] ins, input bit m32, input bit e32);
        exp_t x;
        logic [6:0] op, f7;
        logic [2:0] f3;
        bit known, bad, ur1, ur2, urd, writes;
        int v;
        op = ins[6:0]; f3 = ins[14:12]; f7 = ins[31:25];
        x = '0; known = 1; bad = 0; ur1 = 0; ur2 = 0; urd = 0; writes = 0;
        case (op)
            7'h37, 7'h17: begin urd = 1; writes = 1; x.imm = ins & 32'hFFFFF000; end
            7'h6F: begin
                urd = 1; writes = 1; x.jal = 1;
                v = (ins[31] ? -(1 << 20) : 0) + int'(ins[19:12]) * 4096 + int'(ins[20]) * 2048
                    + int'(ins[30:21]) * 2;
                x.imm = 32'(v);
            end
            7'h67: begin ur1 = 1; urd = 1; writes = 1; x.jalr = 1; x.imm = 32'($signed(ins) >>> 20); bad = (f3 != 0); end
            7'h63: begin
                ur1 = 1; ur2 = 1; x.br = 1; bad = (f3 == 2) || (f3 == 3);
                v = (ins[31] ? -4096 : 0) + int'(ins[7]) * 2048 + int'(ins[30:25]) * 32 + int'(ins[11:8]) * 2;
                x.imm = 32'(v);
            end
            7'h03: begin
                ur1 = 1; urd = 1; writes = 1; x.mem_req = 1; x.imm = 32'($signed(ins) >>> 20);
                bad = (f3 == 3) || (f3 == 6) || (f3 == 7);
            end
            7'h23: begin
                ur1 = 1; ur2 = 1; x.mem_req = 1; x.mem_we = 1; bad = (f3 > 2);
                v = int'($signed(ins) >>> 25) * 32 + int'(ins[11:7]);
                x.imm = 32'(v);
            end
            7'h13: begin
                ur1 = 1; urd = 1; writes = 1; x.imm = 32'($signed(ins) >>> 20);
                bad = (f3 == 1 && f7 != 0) || (f3 == 5 && !(f7 == 0 || f7 == 7'h20));
            end
            7'h33: begin
                ur1 = 1; ur2 = 1; urd = 1; writes = 1; x.mdu_req = (f7 == 1);
                bad = !(f7 == 0 || f7 == 7'h20 || f7 == 1) || (f7 == 7'h20 && !(f3 == 0 || f3 == 5))
                      || (f7 == 1 && !m32);
            end
            7'h0F: begin x.fence = 1; bad = (f3 != 0); end
            7'h73: begin ur1 = 1; urd = 1; x.imm = 32'($signed(ins) >>> 20); end
            default: known = 0;
        endcase
        if (e32 && ((ur1 && ins[19]) || (ur2 && ins[24]) || (urd && ins[11]))) bad = 1;
        x.ill     = !known || bad;
        x.wb_we   = writes && !x.ill;
        x.mem_req = x.mem_req && !x.ill;
        x.mdu_req = x.mdu_req && !x.ill;
        return x;
    endfunction

    function automatic logic [31:0] rand_instr();
        logic [6:0]  opcs [0:10] = '{7'h37, 7'h17, 7'h6F, 7'h67, 7'h63, 7'h03, 7'h23, 7'h13, 7'h33, 7'h0F, 7'h73};
        logic [6:0]  f7s  [0:2]  = '{7'h00, 7'h20, 7'h01};
        logic [31:0] ins;
        int k;
        ins = $urandom;
        k = $urandom_range(0, 11);
        if (k < 11) ins[6:0] = opcs[k];
        if (ins[6:0] == 7'h33 && $urandom_range(0, 3) != 0) ins[31:25] = f7s[$urandom_range(0, 2)];
        if (ins[6:0] == 7'h13 && $urandom_range(0, 1) != 0) ins[31:25] = ($urandom_range(0, 1) != 0) ? 7'h20 : 7'h00;
        if ($urandom_range(0, 1) != 0) begin ins[11] = 1'b0; ins[19] = 1'b0; ins[24] = 1'b0; end
        // Legal FENCEs would stall the random stream waiting for fence_done
        if (ins[6:0] == 7'h0F && ins[14:12] == 3'd0) ins[12] = 1'b1;
        return ins;
    endfunction

    task automatic do_reset();
        @(negedge clk);
        rstn = 1'b0; flush = 1'b0; f_valid = 1'b0; d_ready = 1'b0; fence_done = 1'b0;
        @(negedge clk);
        @(negedge clk);
        rstn = 1'b1;
    endtask

    task automatic test_reset();
        do_reset();
        n_cmp++; if (d_valid_a !== 1'b0) begin n_err++; $display("FAIL reset_dvalid_a: got %0h exp 0", d_valid_a); end
        n_cmp++; if (d_valid_b !== 1'b0) begin n_err++; $display("FAIL reset_dvalid_b: got %0h exp 0", d_valid_b); end
        n_cmp++; if (f_ready_a !== 1'b1) begin n_err++; $display("FAIL reset_fready_a: got %0h exp 1", f_ready_a); end
        n_cmp++; if (cnt_a !== 16'd0) begin n_err++; $display("FAIL reset_cnt_a: got %0h exp 0", cnt_a); end
        n_cmp++; if (imm_a !== 32'd0 || rd_a !== 5'd0 || d_pc_a !== 32'd0) begin
            n_err++; $display("FAIL reset_payload_a: got imm=%0h rd=%0h pc=%0h exp 0", imm_a, rd_a, d_pc_a); end
    endtask

    task automatic test_addi();
        do_reset();
        f_valid = 1'b1; f_instr = ADDI; f_pc = 32'h80; d_ready = 1'b1;
        @(negedge clk);
        f_valid = 1'b0;
        n_cmp++; if (d_valid_a !== 1'b1) begin n_err++; $display("FAIL addi_valid: got %0h exp 1", d_valid_a); end
        n_cmp++; if (rd_a !== 5'd1 || imm_a !== 32'd5 || d_pc_a !== 32'h80) begin
            n_err++; $display("FAIL addi_fields: got rd=%0d imm=%0h pc=%0h exp rd=1 imm=5 pc=80", rd_a, imm_a, d_pc_a); end
        n_cmp++; if (op2_a !== 1'b1 || wb_we_a !== 1'b1 || ill_a !== 1'b0 || wb_src_a !== 3'd0) begin
            n_err++; $display("FAIL addi_ctrl: got op2=%0h wbwe=%0h ill=%0h src=%0h exp 1 1 0 0", op2_a, wb_we_a, ill_a, wb_src_a); end
        @(negedge clk);
        n_cmp++; if (d_valid_a !== 1'b0) begin n_err++; $display("FAIL addi_drain: got %0h exp 0", d_valid_a); end
    endtask

    task automatic test_mul_rv32e();
        do_reset();
        f_valid = 1'b1; f_instr = MUL; f_pc = 32'h90; d_ready = 1'b1;
        @(negedge clk);
        f_instr = ADD16; f_pc = 32'h94;
        n_cmp++; if (mdu_req_a !== 1'b1 || ill_a !== 1'b0 || wb_src_a !== 3'd1) begin
            n_err++; $display("FAIL mul_m1: got mdu=%0h ill=%0h src=%0h exp 1 0 1", mdu_req_a, ill_a, wb_src_a); end
        n_cmp++; if (mdu_req_b !== 1'b0 || ill_b !== 1'b1 || wb_we_b !== 1'b0) begin
            n_err++; $display("FAIL mul_m0: got mdu=%0h ill=%0h wbwe=%0h exp 0 1 0", mdu_req_b, ill_b, wb_we_b); end
        @(negedge clk);
        f_valid = 1'b0;
        n_cmp++; if (cnt_b !== 3'd1 || cnt_a !== 16'd0) begin
            n_err++; $display("FAIL mul_cnt: got a=%0d b=%0d exp a=0 b=1", cnt_a, cnt_b); end
        n_cmp++; if (ill_a !== 1'b0 || wb_we_a !== 1'b1 || rd_a !== 5'd16) begin
            n_err++; $display("FAIL rv32e_off: got ill=%0h wbwe=%0h rd=%0d exp 0 1 16", ill_a, wb_we_a, rd_a); end
        n_cmp++; if (ill_b !== 1'b1 || wb_we_b !== 1'b0) begin
            n_err++; $display("FAIL rv32e_on: got ill=%0h wbwe=%0h exp 1 0", ill_b, wb_we_b); end
    endtask

    task automatic test_back_to_back();
        do_reset();
        d_ready = 1'b0;
        for (int i = 0; i < 3; i++) begin
            f_valid = 1'b1; f_instr = ADDI; f_pc = 32'h100 + 32'(4 * i);
            #1;
            n_cmp++; if (f_ready_a !== (i < 2)) begin
                n_err++; $display("FAIL b2b_ready%0d: got %0h exp %0h", i, f_ready_a, (i < 2)); end
            @(negedge clk);
        end
        f_valid = 1'b0; d_ready = 1'b1;
        n_cmp++; if (d_valid_a !== 1'b1 || d_pc_a !== 32'h100) begin
            n_err++; $display("FAIL b2b_first: got v=%0h pc=%0h exp 1 100", d_valid_a, d_pc_a); end
        @(negedge clk);
        n_cmp++; if (d_valid_a !== 1'b1 || d_pc_a !== 32'h104) begin
            n_err++; $display("FAIL b2b_second: got v=%0h pc=%0h exp 1 104", d_valid_a, d_pc_a); end
        @(negedge clk);
        n_cmp++; if (d_valid_a !== 1'b0) begin n_err++; $display("FAIL b2b_empty: got %0h exp 0", d_valid_a); end
    endtask

    task automatic test_fence();
        do_reset();
        d_ready = 1'b0; f_valid = 1'b1; f_instr = FENCE; f_pc = 32'h200;
        #1;
        n_cmp++; if (f_ready_a !== 1'b1) begin n_err++; $display("FAIL fence_pre_ready: got %0h exp 1", f_ready_a); end
        @(negedge clk);
        f_instr = ADDI; f_pc = 32'h204; fence_done = 1'b1;   // must be ignored while holding
        n_cmp++; if (d_valid_a !== 1'b1 || fence_a !== 1'b1 || f_ready_a !== 1'b0) begin
            n_err++; $display("FAIL fence_hold: got v=%0h fence=%0h rdy=%0h exp 1 1 0", d_valid_a, fence_a, f_ready_a); end
        @(negedge clk);
        fence_done = 1'b0; d_ready = 1'b1;
        n_cmp++; if (f_ready_a !== 1'b0) begin n_err++; $display("FAIL fence_ignore_done: got %0h exp 0", f_ready_a); end
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            n_cmp++; if (f_ready_a !== 1'b0 || d_valid_a !== 1'b0) begin
                n_err++; $display("FAIL fence_wait%0d: got rdy=%0h v=%0h exp 0 0", i, f_ready_a, d_valid_a); end
        end
        fence_done = 1'b1;
        #1;
        n_cmp++; if (f_ready_a !== 1'b0) begin n_err++; $display("FAIL fence_done_cycle: got %0h exp 0", f_ready_a); end
        @(negedge clk);
        fence_done = 1'b0;
        n_cmp++; if (f_ready_a !== 1'b1) begin n_err++; $display("FAIL fence_release: got %0h exp 1", f_ready_a); end
        @(negedge clk);
        f_valid = 1'b0;
        n_cmp++; if (d_valid_a !== 1'b1 || d_pc_a !== 32'h204) begin
            n_err++; $display("FAIL fence_next: got v=%0h pc=%0h exp 1 204", d_valid_a, d_pc_a); end
    endtask

    task automatic test_flush();
        do_reset();
        d_ready = 1'b0; f_valid = 1'b1; f_instr = MUL; f_pc = 32'h300;
        @(negedge clk);
        f_instr = FENCE; f_pc = 32'h304;
        @(negedge clk);
        n_cmp++; if (f_ready_b !== 1'b0 || d_valid_b !== 1'b1 || d_pc_b !== 32'h300) begin
            n_err++; $display("FAIL flush_pre: got rdy=%0h v=%0h pc=%0h exp 0 1 300", f_ready_b, d_valid_b, d_pc_b); end
        flush = 1'b1; f_instr = ADDI; f_pc = 32'h308;
        @(negedge clk);
        flush = 1'b0; f_valid = 1'b0;
        n_cmp++; if (d_valid_b !== 1'b0 || f_ready_b !== 1'b1 || cnt_b !== 3'd0) begin
            n_err++; $display("FAIL flush_post: got v=%0h rdy=%0h cnt=%0d exp 0 1 0", d_valid_b, f_ready_b, cnt_b); end
        @(negedge clk);
        n_cmp++; if (d_valid_b !== 1'b0) begin n_err++; $display("FAIL flush_drop: got %0h exp 0", d_valid_b); end
        f_valid = 1'b1; f_instr = MUL; f_pc = 32'h310;
        @(negedge clk);
        f_valid = 1'b0; d_ready = 1'b1; flush = 1'b1;
        @(negedge clk);
        flush = 1'b0;
        n_cmp++; if (cnt_b !== 3'd1 || d_valid_b !== 1'b0) begin
            n_err++; $display("FAIL flush_handoff: got cnt=%0d v=%0h exp 1 0", cnt_b, d_valid_b); end
    endtask

    task automatic test_random(input int ncyc);
        logic [31:0] q_ins[$];
        logic [31:0] q_pc[$];
        logic [31:0] ins, pc;
        int   cm_a, cm_b;
        exp_t ea, eb, oa, ob;
        bit   hand, acc;
        do_reset();
        cm_a = 0; cm_b = 0;
        for (int c = 0; c < ncyc; c++) begin
            n_cmp++; if (d_valid_a !== (q_ins.size() != 0) || d_valid_b !== (q_ins.size() != 0)) begin
                n_err++; $display("FAIL rnd_valid@%0d: got a=%0h b=%0h exp %0h", c, d_valid_a, d_valid_b, q_ins.size() != 0); end
            n_cmp++; if (f_ready_a !== (q_ins.size() < 2) || f_ready_b !== (q_ins.size() < 2)) begin
                n_err++; $display("FAIL rnd_ready@%0d: got a=%0h b=%0h exp %0h", c, f_ready_a, f_ready_b, q_ins.size() < 2); end
            n_cmp++; if (cnt_a !== 16'(cm_a) || cnt_b !== 3'(cm_b)) begin
                n_err++; $display("FAIL rnd_cnt@%0d: got a=%0d b=%0d exp a=%0d b=%0d", c, cnt_a, cnt_b, cm_a, cm_b); end
            f_valid = ($urandom_range(0, 3) != 0);
            f_instr = rand_instr();
            f_pc    = $urandom;
            d_ready = ($urandom_range(0, 2) != 0);
            #1;
            hand = d_valid_a && d_ready;
            acc  = f_valid && f_ready_a;
            if (hand && q_ins.size() != 0) begin
                ins = q_ins.pop_front();
                pc  = q_pc.pop_front();
                ea  = model(ins, 1'b1, 1'b0);
                eb  = model(ins, 1'b0, 1'b1);
                oa  = {ill_a, wb_we_a, mem_req_a, mem_we_a, mdu_req_a, br_a, jal_a, jalr_a, fence_a, imm_a};
                ob  = {ill_b, wb_we_b, mem_req_b, mem_we_b, mdu_req_b, br_b, jal_b, jalr_b, fence_b, imm_b};
                n_cmp++; if (oa !== ea || d_pc_a !== pc || {rs1_a, rs2_a, rd_a} !== {ins[19:15], ins[24:20], ins[11:7]}) begin
                    n_err++; $display("FAIL rnd_dec_a@%0d ins=%08h: got %h pc=%0h exp %h pc=%0h", c, ins, oa, d_pc_a, ea, pc); end
                n_cmp++; if (ob !== eb || d_pc_b !== pc) begin
                    n_err++; $display("FAIL rnd_dec_b@%0d ins=%08h: got %h pc=%0h exp %h pc=%0h", c, ins, ob, d_pc_b, eb, pc); end
                if (ea.ill && cm_a < 65535) cm_a++;
                if (eb.ill && cm_b < 7) cm_b++;
            end
            if (acc) begin
                q_ins.push_back(f_instr);
                q_pc.push_back(f_pc);
            end
            @(negedge clk);
        end
        f_valid = 1'b0;
    endtask

    initial begin
        test_reset();
        test_addi();
        test_mul_rv32e();
        test_back_to_back();
        test_fence();
        test_flush();
        test_random(3000);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/miriscv_decode_stage.md
Name: miriscv_decode_stage

Overview:
Registered, parametrised decode stage for the miriscv core. It sits between fetch and execute and uses valid/ready handshakes on both sides. A 2-entry skid buffer gives full throughput without a combinational ready path. The stage adds three things to plain decoding: optional RV32M/RV32E legality checks, full immediate generation, and a FENCE serialisation FSM. It also keeps a saturating illegal-instruction counter.

Parameters:
XLEN, 32, datapath/PC width
RV32M, 1, 1 = MUL/DIV legal; 0 = OP with funct7=0x01 is illegal
RV32E, 0, 1 = any used register index >15 is illegal
CNT_W, 16, width of the illegal-instruction counter

Ports:
clk_i  in  1  clock
arstn_i  in  1  reset, synchronous, active-low
flush_i  in  1  discard all held entries
f_valid_i  in  1  fetch entry valid
f_ready_o  out  1  stage accepts entry
f_instr_i  in  32  instruction
f_pc_i  in  XLEN  instruction PC
d_valid_o  out  1  decoded entry valid
d_ready_i  in  1  execute accepts
d_pc_o  out  XLEN  PC of entry
d_rs1_addr_o / d_rs2_addr_o / d_rd_addr_o  out  5 each  register indices
d_imm_o  out  XLEN  sign-extended I/S/B/U/J immediate
d_op1_sel_o / d_op2_sel_o  out  1 each  0 = register, 1 = PC / immediate
d_alu_op_o  out  4  {funct7[5] qualified, funct3}
d_mdu_req_o  out  1  MUL/DIV instruction
d_mdu_op_o  out  3  funct3
d_mem_req_o / d_mem_we_o  out  1 each  load/store request; store
d_mem_size_o  out  3  funct3
d_wb_we_o  out  1  writes rd
d_wb_src_sel_o  out  3  ALU/MDU/LSU/PC/IMM select (package encoding)
d_branch_o / d_jal_o / d_jalr_o / d_fence_o  out  1 each  control class
d_illegal_o  out  1  illegal instruction
fence_done_i  in  1  downstream has drained memory ops for a FENCE
illegal_cnt_o  out  CNT_W  count of illegal entries handed off

Behaviour:
- Reset (arstn_i=0 at a clk_i edge): both entries invalid, FSM=RUN, counter=0, d_valid_o=0. All d_* payload outputs reset to 0.
- Latency: an entry accepted at edge N appears on d_* after edge N (1 cycle). Entries leave in fetch order.
- f_ready_o = (skid entry empty) && (FSM==RUN). It is driven from registers only.
- Skid operation:
  - Output entry is empty, or handoff happens the same cycle: the incoming entry loads the output register.
  - Output entry stalled (d_valid_o && !d_ready_i): the incoming entry goes to the skid register.
  - On handoff, a full skid register moves to the output register.
- Decode is combinational on f_instr_i. The registered results travel with the entry.
  - Opcode legality: LUI, AUIPC, JAL, JALR, BRANCH, LOAD, STORE, OPIMM, OP, FENCE, SYSTEM are legal. Any other opcode, or instr[1:0]!=2'b11, is illegal.
  - Illegal field combinations:
    - LOAD funct3 in {3,6,7}
    - STORE funct3>2
    - BRANCH funct3 in {2,3}
    - JALR/FENCE funct3!=0
    - OP funct7 not in {0x00,0x20,0x01}
    - OP with funct7=0x20 and funct3 not in {0,5}
    - OPIMM shift with a bad funct7
  - RV32E=1: illegal if any register field actually used by the format has bit4 set.
  - An illegal entry forces d_wb_we_o=0, d_mem_req_o=0, d_mdu_req_o=0. It still flows normally so execute can raise the exception.
- FSM states RUN, FENCE_HOLD, FENCE_WAIT:
  - RUN→FENCE_HOLD when a legal FENCE is accepted at the input.
  - FENCE_HOLD→FENCE_WAIT when that FENCE hands off downstream.
  - FENCE_WAIT→RUN on fence_done_i.
  - fence_done_i is ignored outside FENCE_WAIT.
- flush_i (highest priority):
  - Next cycle both entries are invalid and FSM=RUN.
  - An input offered in the flush cycle is dropped, even if f_ready_o=1.
  - A handoff in the flush cycle still completes, because d_valid_o was already high.
- Counter: increments on each handoff with d_illegal_o=1. It saturates at all-ones and is cleared only by reset.

Decomposition:
- miriscv_decode_pkg additions:
  - FSM state enum
  - wb_src encodings (ALU_DATA, MDU_DATA, LSU_DATA, PC_DATA, IMM_DATA)
  - decoded-entry packed struct
  - immediate-type enum
- Opcode constants come from miriscv_opcodes_pkg.
- Sub-module miriscv_decode_logic: purely combinational. Instruction in, decoded struct out, parametrised by RV32M/RV32E. The stage instantiates it once, on the input path.

Test Plan:
- ADDI x1,x0,5 (0x00500093), d_ready_i=1 → one cycle later d_valid_o=1, rd=1, imm=5, op2_sel=1, wb_we=1, illegal=0.
- MUL x0,x1,x2 (0x02208033) with RV32M=0 → d_illegal_o=1, mdu_req=0, illegal_cnt_o=1. With RV32M=1: mdu_req=1, illegal=0.
- ADD x16,x0,x0 (0x00000833) → illegal with RV32E=1, legal with RV32E=0.
- Three back-to-back valids with d_ready_i=0 → two accepted, f_ready_o=0. Release ready → outputs appear in order, no loss or duplication.
- FENCE 0x0FF0000F then ADDI → f_ready_o=0 from the FENCE accept until the cycle after fence_done_i. The ADDI then flows.
- flush_i with both entries full in FENCE_HOLD → next cycle d_valid_o=0, f_ready_o=1, counter unchanged.
